// File: rtl/gfx_pkg.sv
// Shared drawing-pipeline definitions: coordinate width default, rasteriser
// FSM states, octant slot indices and the duplicate-suppression slot masks.
package gfx_pkg;

  localparam int COORD_W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    STEP = 2'd2,
    FIN  = 2'd3
  } state_t;

  localparam logic [2:0] SLOT_FIRST = 3'd0;
  localparam logic [2:0] SLOT_LAST  = 3'd7;

  // Which of the eight symmetric slots produce distinct pixels.
  localparam logic [7:0] MASK_ORIGIN = 8'h01;  // x==0, y==0: single point
  localparam logic [7:0] MASK_AXIS   = 8'h53;  // x==0: slots 0,1,4,6
  localparam logic [7:0] MASK_DIAG   = 8'h0F;  // x==y: slots 0..3
  localparam logic [7:0] MASK_ALL    = 8'hFF;

  function automatic logic [7:0] slot_mask(input logic x_zero,
                                           input logic y_zero,
                                           input logic x_eq_y);
    logic [7:0] m;
    if (x_zero && y_zero) m = MASK_ORIGIN;
    else if (x_zero)      m = MASK_AXIS;
    else if (x_eq_y)      m = MASK_DIAG;
    else                  m = MASK_ALL;
    return m;
  endfunction

endpackage

// File: rtl/circle_octant_map.sv
// Combinational octant mapper: turns (centre, x, y, slot) into one of the
// eight symmetric circle points, plus an enable that drops duplicate slots
// and, when clipping is on, points that fall off screen.
module circle_octant_map
  import gfx_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter bit CLIP_EN  = 1'b1,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic [COORD_W-1:0] cx,
  input  logic [COORD_W-1:0] cy,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [2:0]         slot,
  output logic [COORD_W-1:0] px,
  output logic [COORD_W-1:0] py,
  output logic               en
);

  localparam int SW = COORD_W + 2;
  localparam logic signed [SW-1:0] LIM_X = SW'(SCREEN_W);
  localparam logic signed [SW-1:0] LIM_Y = SW'(SCREEN_H);

  logic signed [SW-1:0] ox, oy, ax, ay;
  logic [7:0]           mask;
  logic                 on_screen;

  // slot[2] swaps the axes, slot[1] negates the first offset, slot[0] the second
  always_comb begin
    ox = slot[2] ? signed'({2'b00, y}) : signed'({2'b00, x});
    oy = slot[2] ? signed'({2'b00, x}) : signed'({2'b00, y});
    if (slot[1]) ox = -ox;
    if (slot[0]) oy = -oy;
    ax = signed'({2'b00, cx}) + ox;
    ay = signed'({2'b00, cy}) + oy;
    mask      = slot_mask(x == '0, y == '0, x == y);
    on_screen = !ax[SW-1] && !ay[SW-1] && (ax < LIM_X) && (ay < LIM_Y);
    en = mask[slot] && (!CLIP_EN || on_screen);
    // unclipped points simply wrap modulo 2^COORD_W
    px = ax[COORD_W-1:0];
    py = ay[COORD_W-1:0];
  end

endmodule

// File: rtl/circle_raster.sv
// Midpoint circle rasteriser. Walks one octant (x from 0 up to y) and emits
// up to eight symmetric points per step over a valid/ready stream, then
// pulses DONE. Output registers are loaded one slot ahead so the first
// point appears in the cycle right after START is accepted.
module circle_raster
  import gfx_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEF,
  parameter bit CLIP_EN  = 1'b1,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  input  logic               START,
  input  logic [COORD_W-1:0] X_0,
  input  logic [COORD_W-1:0] Y_0,
  input  logic [COORD_W-1:0] R,
  output logic               BUSY,
  output logic               PT_VALID,
  input  logic               PT_READY,
  output logic [COORD_W-1:0] X_Out,
  output logic [COORD_W-1:0] Y_Out,
  output logic               DONE
);

  localparam int DW = COORD_W + 3;  // decision variable width
  localparam int EW = COORD_W + 2;  // loop-termination compare width
  localparam logic signed [DW-1:0] K1 = DW'(1);
  localparam logic signed [DW-1:0] K3 = DW'(3);
  localparam logic signed [DW-1:0] K5 = DW'(5);
  localparam logic signed [EW-1:0] E1 = EW'(1);

  state_t               state;
  logic [COORD_W-1:0]   cx, cy, x, y;
  logic signed [DW-1:0] d;
  logic [2:0]           slot;

  logic signed [DW-1:0] dx, dy, d_next;
  logic signed [EW-1:0] x_ext, y_ext;
  logic [COORD_W-1:0]   x_next, y_next;
  logic                 step_last;

  logic [COORD_W-1:0]   m_cx, m_cy, m_x, m_y, m_px, m_py;
  logic [2:0]           m_slot;
  logic                 m_en;

  // Midpoint step; y may go to -1 when R is 0, so compare in a wider signed type
  always_comb begin
    dx    = signed'({3'b000, x});
    dy    = signed'({3'b000, y});
    x_ext = signed'({2'b00, x}) + E1;
    if (d[DW-1]) begin
      d_next = d + (dx <<< 1) + K3;
      y_ext  = signed'({2'b00, y});
    end else begin
      d_next = d + ((dx - dy) <<< 1) + K5;
      y_ext  = signed'({2'b00, y}) - E1;
    end
    x_next    = x_ext[COORD_W-1:0];
    y_next    = y_ext[COORD_W-1:0];
    step_last = x_ext > y_ext;
  end

  // Select what the mapper looks at: the slot about to be loaded into the outputs
  always_comb begin
    m_cx   = cx;
    m_cy   = cy;
    m_x    = x;
    m_y    = y;
    m_slot = slot + 3'd1;
    case (state)
      IDLE: begin
        m_cx   = X_0;
        m_cy   = Y_0;
        m_x    = '0;
        m_y    = R;
        m_slot = SLOT_FIRST;
      end
      STEP: begin
        m_x    = x_next;
        m_y    = y_next;
        m_slot = SLOT_FIRST;
      end
      default: ;
    endcase
  end

  circle_octant_map #(
    .COORD_W (COORD_W),
    .CLIP_EN (CLIP_EN),
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H)
  ) u_map (
    .cx  (m_cx),
    .cy  (m_cy),
    .x   (m_x),
    .y   (m_y),
    .slot(m_slot),
    .px  (m_px),
    .py  (m_py),
    .en  (m_en)
  );

  // Control FSM with registered stream and status outputs
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state    <= IDLE;
      BUSY     <= 1'b0;
      PT_VALID <= 1'b0;
      DONE     <= 1'b0;
      X_Out    <= '0;
      Y_Out    <= '0;
      cx       <= '0;
      cy       <= '0;
      x        <= '0;
      y        <= '0;
      d        <= '0;
      slot     <= SLOT_FIRST;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            cx       <= X_0;
            cy       <= Y_0;
            x        <= '0;
            y        <= R;
            d        <= K1 - signed'({3'b000, R});
            slot     <= SLOT_FIRST;
            BUSY     <= 1'b1;
            PT_VALID <= m_en;
            X_Out    <= m_px;
            Y_Out    <= m_py;
            state    <= EMIT;
          end
        end
        EMIT: begin
          // a disabled slot burns exactly one cycle; an enabled one waits for READY
          if (!PT_VALID || PT_READY) begin
            if (slot == SLOT_LAST) begin
              PT_VALID <= 1'b0;
              state    <= STEP;
            end else begin
              slot     <= slot + 3'd1;
              PT_VALID <= m_en;
              X_Out    <= m_px;
              Y_Out    <= m_py;
            end
          end
        end
        STEP: begin
          d <= d_next;
          x <= x_next;
          y <= y_next;
          if (step_last) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= FIN;
          end else begin
            slot     <= SLOT_FIRST;
            PT_VALID <= m_en;
            X_Out    <= m_px;
            Y_Out    <= m_py;
            state    <= EMIT;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_circle_raster.sv
// Directed bench for circle_raster: a table of circles with hand-derived point
// lists and latencies, plus stall, mid-run START and reset-abort sequences.
module tb_circle_raster;

  localparam int W = 10;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic         START = 1'b0;
  logic         PT_READY = 1'b1;
  logic [W-1:0] X_0 = '0, Y_0 = '0, R = '0;

  logic         busy0, valid0, done0, busy1, valid1, done1;
  logic [W-1:0] xo0, yo0, xo1, yo1;

  circle_raster #(.COORD_W(W), .CLIP_EN(1'b0), .SCREEN_W(320), .SCREEN_H(240)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .X_0(X_0), .Y_0(Y_0), .R(R),
    .BUSY(busy0), .PT_VALID(valid0), .PT_READY(PT_READY), .X_Out(xo0), .Y_Out(yo0),
    .DONE(done0));

  circle_raster #(.COORD_W(W), .CLIP_EN(1'b1), .SCREEN_W(320), .SCREEN_H(240)) dut_clip (
    .ACLK(ACLK), .ARESETN(ARESETN), .START(START), .X_0(X_0), .Y_0(Y_0), .R(R),
    .BUSY(busy1), .PT_VALID(valid1), .PT_READY(PT_READY), .X_Out(xo1), .Y_Out(yo1),
    .DONE(done1));

  always #5 ACLK = ~ACLK;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // accepted points, packed {x,y}
  logic [19:0] q0[$];
  logic [19:0] q1[$];

  always @(negedge ACLK) begin
    if (ARESETN && valid0 && PT_READY) q0.push_back({xo0, yo0});
    if (ARESETN && valid1 && PT_READY) q1.push_back({xo1, yo1});
  end

  // a stalled point must stay put until accepted
  logic        stall_p = 1'b0;
  logic [19:0] stall_pt = '0;
  always @(negedge ACLK) begin
    if (stall_p && ARESETN) begin
      check("stall_valid", valid0, 1);
      check("stall_hold", {xo0, yo0}, stall_pt);
    end
    stall_p  <= ARESETN && valid0 && !PT_READY;
    stall_pt <= {xo0, yo0};
  end

  typedef struct {
    logic [W-1:0]      cx, cy, r;
    bit                clip;
    int                cyc;
    int                n;
    logic [15:0][19:0] pts;
  } vec_t;

  localparam int NV = 7;
  vec_t v[NV];

  task automatic setv(input int i, input int cx, input int cy, input int r,
                      input bit clip, input int cyc);
    v[i].cx = W'(cx); v[i].cy = W'(cy); v[i].r = W'(r);
    v[i].clip = clip; v[i].cyc = cyc; v[i].n = 0; v[i].pts = '0;
  endtask

  task automatic add(input int i, input int x, input int y);
    v[i].pts[v[i].n] = {W'(x), W'(y)};
    v[i].n++;
  endtask

  task automatic run(input logic [W-1:0] cx, input logic [W-1:0] cy, input logic [W-1:0] r,
                     input bit clip, input bit stall, input int inj_at, output int cyc);
    bit seen;
    q0.delete();
    q1.delete();
    @(posedge ACLK); #1;
    X_0 = cx; Y_0 = cy; R = r; START = 1'b1; PT_READY = 1'b1;
    @(posedge ACLK); #1;
    START = 1'b0;
    if (stall) PT_READY = 1'($urandom_range(0, 1));
    seen = 1'b0;
    @(negedge ACLK);
    cyc = 1;
    check("busy_rise", clip ? busy1 : busy0, 1);
    while (cyc < 2000) begin
      if (clip ? done1 : done0) begin
        seen = 1'b1;
        break;
      end
      @(posedge ACLK); #1;
      if (stall) PT_READY = 1'($urandom_range(0, 1));
      if (cyc == inj_at) begin
        START = 1'b1; X_0 = 10'd100; Y_0 = 10'd50; R = 10'd5;
      end else START = 1'b0;
      @(negedge ACLK);
      cyc++;
    end
    START = 1'b0;
    check("done_seen", seen, 1);
    check("busy_at_done", clip ? busy1 : busy0, 0);
    PT_READY = 1'b1;
    for (int k = 0; k < 100 && (busy0 || busy1); k++) @(negedge ACLK);
  endtask

  task automatic cmp_pts(input string tag, input vec_t e, input bit clip);
    int n;
    n = clip ? q1.size() : q0.size();
    check($sformatf("%s_count", tag), n, e.n);
    for (int k = 0; k < e.n && k < n; k++)
      check($sformatf("%s_pt%0d", tag, k), clip ? q1[k] : q0[k], e.pts[k]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int dn;

    setv(0, 5, 7, 0, 0, 10);      add(0, 5, 7);
    setv(1, 10, 10, 1, 0, 10);
    add(1, 10, 11); add(1, 10, 9); add(1, 11, 10); add(1, 9, 10);
    setv(2, 20, 20, 3, 0, 28);
    add(2, 20, 23); add(2, 20, 17); add(2, 23, 20); add(2, 17, 20);
    add(2, 21, 23); add(2, 21, 17); add(2, 19, 23); add(2, 19, 17);
    add(2, 23, 21); add(2, 23, 19); add(2, 17, 21); add(2, 17, 19);
    add(2, 22, 22); add(2, 22, 18); add(2, 18, 22); add(2, 18, 18);
    setv(3, 1, 1, 3, 1, 28);
    add(3, 1, 4); add(3, 4, 1); add(3, 2, 4); add(3, 0, 4);
    add(3, 4, 2); add(3, 4, 0); add(3, 3, 3);
    setv(4, 0, 0, 1, 0, 10);
    add(4, 0, 1); add(4, 0, 1023); add(4, 1, 0); add(4, 1023, 0);
    setv(5, 0, 0, 1, 1, 10);      add(5, 0, 1); add(5, 1, 0);
    setv(6, 319, 239, 1, 1, 10);  add(6, 319, 238); add(6, 318, 239);

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check("rst_busy", busy0, 0);
    check("rst_valid", valid0, 0);
    check("rst_done", done0, 0);
    check("rst_xy", {xo0, yo0}, 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run(v[i].cx, v[i].cy, v[i].r, v[i].clip, 1'b0, -1, cyc);
      check($sformatf("v%0d_cycles", i), cyc, v[i].cyc);
      cmp_pts($sformatf("v%0d", i), v[i], v[i].clip);
    end

    // random backpressure: same sequence, only slower
    run(10'd20, 10'd20, 10'd3, 1'b0, 1'b1, -1, cyc);
    check("stall_min_cycles", cyc >= 28, 1);
    cmp_pts("stall", v[2], 1'b0);

    // second START and new operands mid-run are ignored
    run(10'd20, 10'd20, 10'd3, 1'b0, 1'b0, 5, cyc);
    check("inject_cycles", cyc, 28);
    cmp_pts("inject", v[2], 1'b0);

    // reset during slot 5 of the second step
    @(posedge ACLK); #1;
    X_0 = 10'd20; Y_0 = 10'd20; R = 10'd3; START = 1'b1; PT_READY = 1'b1;
    @(posedge ACLK); #1;
    START = 1'b0;
    repeat (14) @(posedge ACLK);
    #1;
    ARESETN = 1'b0;
    @(negedge ACLK);
    check("abort_slot5_pt", {xo0, yo0}, {10'd23, 10'd19});
    check("abort_slot5_busy", busy0, 1);
    @(negedge ACLK);
    check("abort_busy", busy0, 0);
    check("abort_valid", valid0, 0);
    check("abort_xy", {xo0, yo0}, 0);
    check("abort_done", done0, 0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge ACLK);
      if (done0) dn++;
    end
    check("abort_no_done", dn, 0);
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
    run(10'd20, 10'd20, 10'd3, 1'b0, 1'b0, -1, cyc);
    check("restart_cycles", cyc, 28);
    cmp_pts("restart", v[2], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/circle_raster.md
# circle_raster

Parametrised midpoint-circle rasteriser for the SuperGA drawing pipeline. It accepts a centre and radius on a START pulse and walks the full eight-way-symmetric midpoint algorithm, emitting one pixel coordinate per valid/ready handshake. It suppresses duplicate pixels and, optionally, pixels outside the screen, then pulses DONE. It sits between the command decoder and the framebuffer write arbiter.

## Interface
- COORD_W, 10, coordinate and radius width (unsigned)
- CLIP_EN, 1, 1 = suppress points outside the screen; 0 = emit all points, wrapped modulo 2^COORD_W
- SCREEN_W, 320, screen width in pixels (clip bound, x < SCREEN_W)
- SCREEN_H, 240, screen height in pixels (clip bound, y < SCREEN_H)
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  reset, synchronous, active-low
- START  in  1  one-cycle request; sampled only in IDLE
- X_0, Y_0  in  COORD_W  centre, latched on accepted START
- R  in  COORD_W  radius, latched on accepted START
- BUSY  out  1  high from the cycle after accepted START until DONE
- PT_VALID  out  1  X_Out/Y_Out hold a point
- PT_READY  in  1  consumer accepts the point when PT_VALID && PT_READY
- X_Out, Y_Out  out  COORD_W  point coordinates
- DONE  out  1  one-cycle pulse after the last slot completes

## Operation
- States: IDLE, EMIT, STEP, FIN. Reset puts the block in IDLE with BUSY=0, PT_VALID=0, DONE=0, X_Out=0, Y_Out=0.
- IDLE: when START=1, latch X_0/Y_0/R. Initialise x=0, y=R, d=1−R (signed, COORD_W+3 bits) and slot=0. Go to EMIT.
- EMIT: slot 0..7 maps to these points:
  - 0: (+x,+y), 1: (+x,−y), 2: (−x,+y), 3: (−x,−y)
  - 4: (+y,+x), 5: (+y,−x), 6: (−y,+x), 7: (−y,−x)
  - Each offset is added to the centre in COORD_W+2 signed arithmetic.
- Slot enable rules:
  - x==0 && y==0: slot 0 only.
  - x==0: slots 0, 1, 4, 6.
  - x==y: slots 0–3.
  - Otherwise: all eight slots.
  - With CLIP_EN, a slot is also disabled if the point is <0 or ≥ SCREEN_W/SCREEN_H.
- Enabled slot: hold PT_VALID=1 until the handshake. Disabled slot: PT_VALID=0 for exactly one cycle. In both cases slot then increments.
- Leaving slot 7 goes to STEP, which takes one cycle:
  - If d<0: d += 2x+3.
  - Else: d += 2(x−y)+5 and y −= 1.
  - Then x += 1.
  - If the new x > y, go to FIN; otherwise go to EMIT with slot=0.
- FIN: DONE=1 and BUSY=0 for one cycle, then IDLE.
- START while not in IDLE is ignored.
- Changes on X_0/Y_0/R while busy have no effect.
- ARESETN low in any state aborts the operation next edge. No DONE is produced, and any pending point is dropped.

## Timing
- Accepted START at edge n gives BUSY=1 and the first slot at n+1.
- PT_VALID, X_Out and Y_Out are registered. They are stable while PT_VALID && !PT_READY.
- Each slot takes at least one cycle. Each STEP adds one cycle, and DONE adds one cycle.
- Total cycles for one circle with no backpressure: 9·steps + 1.
- R=0 with PT_READY tied high:
  - START at n, point (X_0,Y_0) at n+1.
  - Slots 1–7 at n+2..n+8, STEP at n+9, DONE at n+10.
- Back-to-back: START is accepted in the cycle after DONE, when the block is back in IDLE.

## Structure
- Shared package gfx_pkg holds:
  - The COORD_W default.
  - The state enum (IDLE/EMIT/STEP/FIN).
  - Slot index constants and the duplicate-slot masks.
- Sub-module circle_octant_map is combinational. It takes centre, x, y, slot and clip parameters, and outputs the point and an enable. It is reusable by a future filled-circle block.

## Test plan
- Centre (10,10), R=1, READY=1 → points (10,11), (10,9), (11,10), (9,10) in that order, then DONE. Exactly 4 points.
- Centre (20,20), R=3 → 16 points:
  - (20,23), (20,17), (23,20), (17,20)
  - (21,23), (21,17), (19,23), (19,17), (23,21), (23,19), (17,21), (17,19)
  - (22,22), (22,18), (18,22), (18,18)
- Centre (1,1), R=3, CLIP_EN=1 → exactly 7 points in this order:
  - (1,4), (4,1), (2,4), (0,4), (4,2), (4,0), (3,3)
- R=3 run with random PT_READY stalls → the same 16-point sequence. Outputs stay stable while stalled, and no point is lost or duplicated.
- START pulsed again mid-run with different X_0/R → ignored, and the original sequence completes.
- ARESETN low during slot 5 of the second step → next cycle BUSY=0, PT_VALID=0, outputs 0 and no DONE. A new START then runs cleanly from the beginning.
